cnn_frame_ctrl: RTL
===================

Name: cnn_frame_ctrl

Overview:
Frame-level sequencer for the 5x5 convolution core.
- On a start command, reads one IMG_W x IMG_H input frame from a single-port frame RAM in raster order.
- Streams the pixels into the core's valid/pixel input and honours a downstream hold.
- Counts and tags the core's output-valid strobes with (row, col) output coordinates.
- Raises a done pulse once every expected output pixel has been produced.

Parameters:
- IMG_W, 28, input frame width in pixels
- IMG_H, 28, input frame height in pixels
- KX, 5, kernel width
- KY, 5, kernel height
- I_F_BW, 8, input pixel width
- ADDR_BW, 10, frame RAM address width; must satisfy 2^ADDR_BW >= IMG_W*IMG_H
- TIMEOUT, 64, drain watchdog limit in cycles (used only with the optional feature)

Ports:
- clk, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- i_start, in, 1, start one frame; sampled in IDLE only
- i_hold, in, 1, stall pixel issue while high
- o_busy, out, 1, high in STREAM and DRAIN
- o_done, out, 1, one-cycle pulse at frame completion
- o_mem_rd_en, out, 1, frame RAM read strobe
- o_mem_addr, out, ADDR_BW, frame RAM read address
- i_mem_rdata, in, I_F_BW, RAM read data, valid 1 cycle after o_mem_rd_en
- o_core_valid, out, 1, pixel valid to the core
- o_core_fmap, out, I_F_BW, pixel to the core
- i_core_ot_valid, in, 1, core output-valid strobe
- o_out_row, out, 8, output row of the current i_core_ot_valid
- o_out_col, out, 8, output column of the current i_core_ot_valid
- o_err, out, 1, sticky watchdog error (optional feature only; otherwise tied 0)

Behaviour:
- Derived values:
  - OW = IMG_W-KX+1
  - OH = IMG_H-KY+1
  - NPIX = IMG_W*IMG_H
  - NOUT = OW*OH
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - i_start=1 -> STREAM; rd_addr counter cleared; out counters cleared.
  - i_core_ot_valid in IDLE is ignored (not counted).
- STREAM, per cycle:
  - i_hold=0: o_mem_rd_en=1, o_mem_addr=rd_addr, rd_addr++.
  - i_hold=1: o_mem_rd_en=0 and the address holds.
  - The cycle issuing address NPIX-1 transitions to DRAIN.
  - o_mem_rd_en and o_mem_addr are registered outputs.
- Pixel path:
  - o_core_valid = o_mem_rd_en delayed one cycle (registered).
  - o_core_fmap = i_mem_rdata when o_core_valid=1, else 0.
  - i_hold does not cancel a read already issued; its pixel is still delivered next cycle.
- Output counting (STREAM and DRAIN):
  - Each i_core_ot_valid presents the current (o_out_row, o_out_col).
  - After the strobe, col increments; at OW-1 it wraps to 0 and row increments.
  - out_cnt increments on each strobe.
  - Coordinates are valid only in the cycle of the strobe.
- DRAIN: waits for out_cnt to reach NOUT. The strobe that makes out_cnt=NOUT moves the FSM to DONE.
- DONE: o_done=1 for exactly one cycle; o_busy=0; next state IDLE.
- o_busy: registered, 1 iff state is STREAM or DRAIN.
- i_start handling:
  - Ignored in STREAM, DRAIN and DONE.
  - An i_start held continuously high restarts a new frame from IDLE on the cycle after DONE.
- Core contract: the core emits exactly NOUT strobes per frame. Extra strobes after done fall in IDLE and are ignored.
- Asynchronous reset mid-frame: immediate return to IDLE with all counters and outputs cleared. No partial done is signalled.

Optional Feature:
Macro CNN_FRAME_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in DRAIN and clears on every i_core_ot_valid.
  - When the counter reaches TIMEOUT, the FSM goes to DONE: o_done pulses and o_err=1.
  - o_err stays set until the next accepted i_start or reset.
- Not defined: no watchdog; DRAIN waits indefinitely; o_err is constant 0.

Test Plan:
- Setup for all scenarios: IMG_W=IMG_H=8, KX=KY=5 (OW=OH=4, NPIX=64, NOUT=16); a RAM model returns data = addr.
- Basic frame: i_start pulse, i_hold=0.
  - Addresses 0..63 are issued on 64 consecutive cycles.
  - o_core_fmap sequence is 0..63, each one cycle after its address.
  - A 16-strobe core model gives coords (0,0)..(3,3).
  - o_done pulses once, 1 cycle after the 16th strobe.
- Hold: i_hold high for cycles 10-14 of STREAM.
  - Address stops at 10 during the hold, then resumes at 10; no pixel is duplicated or dropped.
  - Total of 64 o_core_valid pulses.
- Start while busy: i_start pulsed mid-STREAM and in DONE.
  - No restart, counters undisturbed.
  - With i_start held high across DONE, the next frame begins at address 0.
- Reset mid-frame: reset_n low at address 30.
  - All outputs 0, FSM in IDLE.
  - A new i_start streams from address 0 and completes normally.
- Stray strobes: i_core_ot_valid pulsed 3 times in IDLE, then a full frame run.
  - The frame still needs exactly 16 in-frame strobes.
  - The first in-frame coordinate is (0,0).
- Timeout (macro defined, TIMEOUT=64): the core model stops after 10 strobes.
  - 64 cycles after the last strobe, o_done pulses and o_err=1.
  - o_err clears on the next i_start.

Source files
------------

// File: rtl/cnn_frame_ctrl_if.sv
// Frame-RAM read port and convolution-core pixel/output-strobe bundle for cnn_frame_ctrl.
// master = frame sequencer, slave = RAM/core side.
interface cnn_frame_ctrl_if #(
    parameter int I_F_BW  = 8,
    parameter int ADDR_BW = 10
);
    logic               o_mem_rd_en;
    logic [ADDR_BW-1:0] o_mem_addr;
    logic [I_F_BW-1:0]  i_mem_rdata;
    logic               o_core_valid;
    logic [I_F_BW-1:0]  o_core_fmap;
    logic               i_core_ot_valid;
    logic [7:0]         o_out_row;
    logic [7:0]         o_out_col;

    modport master (
        output o_mem_rd_en, o_mem_addr,
        input  i_mem_rdata,
        output o_core_valid, o_core_fmap,
        input  i_core_ot_valid,
        output o_out_row, o_out_col
    );

    modport slave (
        input  o_mem_rd_en, o_mem_addr,
        output i_mem_rdata,
        input  o_core_valid, o_core_fmap,
        output i_core_ot_valid,
        input  o_out_row, o_out_col
    );
endinterface

// File: rtl/cnn_frame_ctrl.sv
// Frame sequencer for the 5x5 convolution core: streams one frame from RAM, tags output strobes.
// Optional drain watchdog with sticky o_err is enabled by defining CNN_FRAME_CTRL_TIMEOUT_EN.
module cnn_frame_ctrl #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int KX      = 5,
    parameter int KY      = 5,
    parameter int I_F_BW  = 8,
    parameter int ADDR_BW = 10,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_hold,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    cnn_frame_ctrl_if.master bus
);
    localparam int OW     = IMG_W - KX + 1;
    localparam int OH     = IMG_H - KY + 1;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NOUT   = OW * OH;
    localparam int CNT_BW = $clog2(NOUT + 1);

    if (((1 << ADDR_BW) < NPIX) || (TIMEOUT < 2)) begin : g_bad_cfg
        $error("cnn_frame_ctrl: ADDR_BW too small for frame or TIMEOUT < 2");
    end

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t             state, state_nx;
    logic [ADDR_BW-1:0] rd_addr, rd_addr_nx, addr_nx;
    logic               rd_en_nx, clr, strobe, last_out, timeout;
    logic [7:0]         row, col;
    logic [CNT_BW-1:0]  out_cnt;

    assign strobe   = bus.i_core_ot_valid && (state == STREAM || state == DRAIN);
    // Also covers a core that finishes its strobes before the last pixel is issued.
    assign last_out = (out_cnt == CNT_BW'(NOUT)) ||
                      (strobe && out_cnt == CNT_BW'(NOUT - 1));

`ifdef CNN_FRAME_CTRL_TIMEOUT_EN
    localparam int WD_BW = $clog2(TIMEOUT + 1);
    logic [WD_BW-1:0] wd_cnt;

    assign timeout = (state == DRAIN) && !strobe && (wd_cnt == WD_BW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            o_err  <= 1'b0;
        end else begin
            if (state != DRAIN || strobe) wd_cnt <= '0;
            else                          wd_cnt <= wd_cnt + 1'b1;
            if (clr)                         o_err <= 1'b0;
            else if (timeout && !last_out)   o_err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign o_err   = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        rd_addr_nx = rd_addr;
        addr_nx    = bus.o_mem_addr;
        rd_en_nx   = 1'b0;
        clr        = 1'b0;
        unique case (state)
            IDLE: if (i_start) begin
                state_nx   = STREAM;
                rd_addr_nx = '0;
                clr        = 1'b1;
            end
            STREAM: if (!i_hold) begin
                rd_en_nx   = 1'b1;
                addr_nx    = rd_addr;
                rd_addr_nx = rd_addr + 1'b1;
                if (rd_addr == ADDR_BW'(NPIX - 1)) state_nx = DRAIN;
            end
            DRAIN:   if (last_out || timeout) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            rd_addr          <= '0;
            bus.o_mem_rd_en  <= 1'b0;
            bus.o_mem_addr   <= '0;
            bus.o_core_valid <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            row              <= '0;
            col              <= '0;
            out_cnt          <= '0;
        end else begin
            state            <= state_nx;
            rd_addr          <= rd_addr_nx;
            bus.o_mem_rd_en  <= rd_en_nx;
            bus.o_mem_addr   <= addr_nx;
            bus.o_core_valid <= bus.o_mem_rd_en;
            o_busy           <= (state_nx == STREAM) || (state_nx == DRAIN);
            o_done           <= (state_nx == DONE);
            if (clr) begin
                row     <= '0;
                col     <= '0;
                out_cnt <= '0;
            end else if (strobe) begin
                out_cnt <= out_cnt + 1'b1;
                if (col == 8'(OW - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign bus.o_core_fmap = bus.o_core_valid ? bus.i_mem_rdata : '0;
    assign bus.o_out_row   = strobe ? row : '0;
    assign bus.o_out_col   = strobe ? col : '0;
endmodule
